// File: rtl/ahb3lite_intc_pkg.sv
// ahb3lite_intc_pkg
// Register offsets, request struct and byte-lane helpers for ahb3lite_intc.
package ahb3lite_intc_pkg;
   import ahb3lite_pkg::*;

   localparam int OFS_W = 8;  // decoded offset bits; HSEL does the block decode
   localparam int ID_W  = 5;  // source IDs 1..31, 0 = none

   localparam logic [OFS_W-1:0] REG_PENDING   = 8'h00;
   localparam logic [OFS_W-1:0] REG_ENABLE    = 8'h04;
   localparam logic [OFS_W-1:0] REG_EDGE      = 8'h08;
   localparam logic [OFS_W-1:0] REG_THRESHOLD = 8'h0C;
   localparam logic [OFS_W-1:0] REG_CLAIM     = 8'h10;
   localparam logic [OFS_W-1:0] REG_PRIO_BASE = 8'h20;

   // registered write address phase
   typedef struct packed {
      logic             we;
      logic [OFS_W-1:0] ofs;
      logic [3:0]       be;
   } intc_req_t;

   function automatic logic [3:0] gen_be(input logic [2:0] hsize, input logic [1:0] a);
      case (hsize)
         HSIZE_BYTE:  gen_be = 4'b0001 << a;
         HSIZE_HWORD: gen_be = a[1] ? 4'b1100 : 4'b0011;
         default:     gen_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [31:0] wdata,
                                            input logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old & ~m) | (wdata & m);
   endfunction
endpackage

// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg
// Shared AHB3-Lite encodings (HTRANS, HSIZE, HRESP) used by all slaves on the bus.
package ahb3lite_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb3lite_intc_arbiter.sv
// ahb3lite_intc_arbiter
// Combinational picker: highest priority among eligible sources, lowest ID on a tie.
//   eligible_i  : per-source eligibility
//   prio_i      : per-source priority
//   best_id_o   : winning ID (source n -> n+1), 0 when nothing eligible
//   best_prio_o : priority of the winner, 0 when nothing eligible
module ahb3lite_intc_arbiter
   import ahb3lite_intc_pkg::*;
#(
   parameter int SOURCES   = 8,
   parameter int PRIO_BITS = 3
) (
   input  logic [SOURCES-1:0]                eligible_i,
   input  logic [SOURCES-1:0][PRIO_BITS-1:0] prio_i,
   output logic [ID_W-1:0]                   best_id_o,
   output logic [PRIO_BITS-1:0]              best_prio_o
);

   // Scan from the top ID down with >=, so an equal priority at a lower ID
   // replaces the current winner.
   always_comb begin
      best_id_o   = '0;
      best_prio_o = '0;
      for (int n = SOURCES - 1; n >= 0; n--) begin
         if (eligible_i[n] && (prio_i[n] >= best_prio_o)) begin
            best_id_o   = ID_W'(n + 1);
            best_prio_o = prio_i[n];
         end
      end
   end

endmodule

// File: rtl/ahb3lite_intc.sv
// ahb3lite_intc
// AHB3-Lite interrupt controller: per-source gateway/pending/enable/priority,
// threshold, claim/complete register and a registered irq to the CPU.
//   HCLK, HRESETn        : clock, async active-low reset
//   HSEL..HREADY         : AHB3-Lite slave inputs
//   HRDATA, HREADYOUT,
//   HRESP                : AHB3-Lite slave outputs (zero wait state, always OKAY)
//   src                  : interrupt lines, synchronous to HCLK
//   irq                  : registered interrupt request
// Build option: AHB3LITE_INTC_EDGE_EN adds the EDGE register and edge gateways.
module ahb3lite_intc
   import ahb3lite_pkg::*;
   import ahb3lite_intc_pkg::*;
#(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int SOURCES    = 8,
   parameter int PRIO_BITS  = 3
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   output logic [HDATA_SIZE-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   input  logic [SOURCES-1:0]    src,
   output logic                  irq
);

   intc_req_t                         req_q;
   logic                              acc, rd_acc, wr_commit, claim, complete;
   logic [OFS_W-1:0]                  rd_ofs;
   logic [SOURCES-1:0]                pending_q, pending_d, enable_q, enable_d;
   logic [SOURCES-1:0]                inservice_q, inservice_d;
   logic [SOURCES-1:0]                gw_set, claim_vec, cmp_vec, eligible;
   logic [SOURCES-1:0][PRIO_BITS-1:0] prio_q, prio_d;
   logic [PRIO_BITS-1:0]              thresh_q, thresh_d, best_prio_q, arb_prio;
   logic [ID_W-1:0]                   best_id_q, arb_id;
   logic                              irq_q;
   logic [31:0]                       rdata, edge_rd, hrdata_q;
   logic                              unused_ok;

   assign unused_ok = ^{HADDR[HADDR_SIZE-1:OFS_W], HBURST, HPROT, HTRANS[0]};

   // HTRANS[1] covers NONSEQ and SEQ
   assign acc       = HSEL & HREADY & HTRANS[1];
   assign rd_acc    = acc & ~HWRITE;
   assign rd_ofs    = {HADDR[OFS_W-1:2], 2'b00};
   assign wr_commit = req_q.we & HREADY;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         req_q <= '0;
      end else if (HREADY) begin
         req_q.we  <= acc & HWRITE;
         req_q.ofs <= rd_ofs;
         req_q.be  <= gen_be(HSIZE, HADDR[1:0]);
      end
   end

   // claim/complete decode
   assign claim     = rd_acc && (rd_ofs == REG_CLAIM) && (best_id_q != '0);
   assign claim_vec = claim ? (SOURCES'(1) << (best_id_q - 1'b1)) : '0;
   assign complete  = wr_commit && (req_q.ofs == REG_CLAIM) && (HWDATA != '0) &&
                      (HWDATA <= HDATA_SIZE'(SOURCES));
   assign cmp_vec   = complete ? (SOURCES'(1) << (HWDATA[ID_W-1:0] - 1'b1)) : '0;

   // software-visible register writes
   always_comb begin
      enable_d = enable_q;
      thresh_d = thresh_q;
      prio_d   = prio_q;
      if (wr_commit) begin
         if (req_q.ofs == REG_ENABLE)
            enable_d = SOURCES'(wr_merge(32'(enable_q), HWDATA, req_q.be));
         if (req_q.ofs == REG_THRESHOLD)
            thresh_d = PRIO_BITS'(wr_merge(32'(thresh_q), HWDATA, req_q.be));
         for (int n = 0; n < SOURCES; n++)
            if (req_q.ofs == REG_PRIO_BASE + OFS_W'(4 * n))
               prio_d[n] = PRIO_BITS'(wr_merge(32'(prio_q[n]), HWDATA, req_q.be));
      end
   end

   assign inservice_d = (inservice_q & ~cmp_vec) | claim_vec;

`ifdef AHB3LITE_INTC_EDGE_EN
   logic [SOURCES-1:0] edge_q, edge_d, src_q;

   assign edge_d = (wr_commit && req_q.ofs == REG_EDGE) ?
                   SOURCES'(wr_merge(32'(edge_q), HWDATA, req_q.be)) : edge_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         edge_q <= '0;
         src_q  <= '0;
      end else begin
         edge_q <= edge_d;
         src_q  <= src;
      end
   end

   // edge sources latch a rising edge even in service; level sources are held
   // off by the in-service bit, including one set by a claim this cycle
   assign gw_set  = (edge_q & src & ~src_q) | (~edge_q & src & ~inservice_d);
   assign edge_rd = 32'(edge_q);
`else
   assign gw_set  = src & ~inservice_d;
   assign edge_rd = '0;
`endif

   // gateway set wins over a same-cycle claim clear
   assign pending_d = (pending_q & ~claim_vec) | gw_set;

   // arbitrate on next-state so a claim drops its source at the same edge
   always_comb begin
      for (int n = 0; n < SOURCES; n++)
         eligible[n] = pending_d[n] & enable_d[n] & ~inservice_d[n] & (prio_d[n] > thresh_d);
   end

   ahb3lite_intc_arbiter #(
      .SOURCES   (SOURCES),
      .PRIO_BITS (PRIO_BITS)
   ) u_arb (
      .eligible_i  (eligible),
      .prio_i      (prio_d),
      .best_id_o   (arb_id),
      .best_prio_o (arb_prio)
   );

   always_comb begin
      rdata = '0;
      case (rd_ofs)
         REG_PENDING:   rdata = 32'(pending_q);
         REG_ENABLE:    rdata = 32'(enable_q);
         REG_EDGE:      rdata = edge_rd;
         REG_THRESHOLD: rdata = 32'(thresh_q);
         REG_CLAIM:     rdata = 32'(best_id_q);
         default:       ;
      endcase
      for (int n = 0; n < SOURCES; n++)
         if (rd_ofs == REG_PRIO_BASE + OFS_W'(4 * n)) rdata = 32'(prio_q[n]);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pending_q   <= '0;
         enable_q    <= '0;
         inservice_q <= '0;
         prio_q      <= '0;
         thresh_q    <= '0;
         best_id_q   <= '0;
         best_prio_q <= '0;
         irq_q       <= 1'b0;
         hrdata_q    <= '0;
      end else begin
         pending_q   <= pending_d;
         enable_q    <= enable_d;
         inservice_q <= inservice_d;
         prio_q      <= prio_d;
         thresh_q    <= thresh_d;
         best_id_q   <= arb_id;
         best_prio_q <= arb_prio;
         irq_q       <= (best_prio_q > thresh_q) && (best_id_q != '0);
         if (rd_acc) hrdata_q <= rdata;
      end
   end

   assign HRDATA    = HDATA_SIZE'(hrdata_q);
   assign HREADYOUT = 1'b1;
   assign HRESP     = HRESP_OKAY;
   assign irq       = irq_q;

endmodule

// File: tb/tb_ahb3lite_intc.sv
// tb_ahb3lite_intc
// Directed plus randomized bench for ahb3lite_intc against a source-level
// reference model (pending/in-service sets and a priority pick).
module tb_ahb3lite_intc;
   localparam int NS = 8;
   localparam logic [31:0] A_PEND = 32'h00, A_EN = 32'h04, A_EDGE = 32'h08,
                           A_THR = 32'h0C, A_CLAIM = 32'h10;

   logic          HCLK = 1'b0, HRESETn;
   logic          HSEL, HWRITE, HREADY, HREADYOUT, HRESP, irq;
   logic [31:0]   HADDR, HWDATA, HRDATA;
   logic [2:0]    HSIZE, HBURST;
   logic [3:0]    HPROT;
   logic [1:0]    HTRANS;
   logic [NS-1:0] src;

   ahb3lite_intc #(.HADDR_SIZE(32), .HDATA_SIZE(32), .SOURCES(NS), .PRIO_BITS(3)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
      .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .src(src), .irq(irq));

   always #5 HCLK = ~HCLK;

   int checks = 0, failures = 0;
   bit [NS-1:0] m_pend, m_ins, m_en, m_edge, m_src;
   int m_prio[NS];
   int m_thr;
   logic [31:0] rd;
   int id;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_pend = '0; m_ins = '0; m_en = '0; m_edge = '0; m_src = '0; m_thr = 0;
      foreach (m_prio[n]) m_prio[n] = 0;
   endtask

   // highest priority above threshold among pending, enabled, idle sources;
   // strict > while walking up from ID 1 keeps the lowest ID on a tie
   function automatic int m_best();
      int best = 0, bp = 0;
      for (int n = 0; n < NS; n++)
         if (m_pend[n] && m_en[n] && !m_ins[n] && m_prio[n] > m_thr && m_prio[n] > bp) begin
            best = n + 1; bp = m_prio[n];
         end
      return best;
   endfunction

   task automatic m_settle();
      for (int n = 0; n < NS; n++)
         if (!m_edge[n] && m_src[n] && !m_ins[n]) m_pend[n] = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] sz = 3'd2);
      HSEL = 1; HADDR = a; HWRITE = 1; HTRANS = 2'b10; HSIZE = sz;
      @(posedge HCLK); #1;
      HSEL = 0; HWRITE = 0; HTRANS = 2'b00; HSIZE = 3'd2; HWDATA = d;
      @(posedge HCLK); #1;
      HWDATA = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      HSEL = 1; HADDR = a; HWRITE = 0; HTRANS = 2'b10; HSIZE = 3'd2;
      @(posedge HCLK); #1;
      HSEL = 0; HTRANS = 2'b00;
      d = HRDATA;
   endtask

   task automatic set_prio(input int n, input int p);
      bus_write(32'h20 + 32'(4 * n), 32'(p)); m_prio[n] = p;
   endtask
   task automatic set_en(input bit [NS-1:0] v);
      bus_write(A_EN, 32'(v)); m_en = v;
   endtask
   task automatic set_thr(input int t);
      bus_write(A_THR, 32'(t)); m_thr = t;
   endtask
   task automatic set_src(input bit [NS-1:0] v);
      for (int n = 0; n < NS; n++)
         if (m_edge[n] && v[n] && !m_src[n]) m_pend[n] = 1'b1;
      m_src = v; src = v;
      m_settle();
   endtask
   task automatic pulse(input int n);
      set_src(m_src | (NS'(1) << n)); idle(1);
      set_src(m_src & ~(NS'(1) << n)); idle(1);
   endtask

   task automatic claim_chk(input string tag, output int exp);
      logic [31:0] d;
      exp = m_best();
      bus_read(A_CLAIM, d);
      chk(tag, d, 32'(exp));
      if (exp != 0) begin m_pend[exp-1] = 1'b0; m_ins[exp-1] = 1'b1; end
   endtask
   task automatic complete(input int k);
      bus_write(A_CLAIM, 32'(k));
      if (k >= 1 && k <= NS) m_ins[k-1] = 1'b0;
      m_settle();
   endtask
   task automatic chk_irq(input string tag);
      idle(2);
      chk(tag, {31'b0, irq}, {31'b0, m_best() != 0});
   endtask
   task automatic drain(input string tag);
      int ids[$];
      int e;
      set_src('0);
      for (int i = 0; i < NS + 2; i++) begin
         claim_chk(tag, e);
         if (e == 0) break;
         ids.push_back(e);
      end
      foreach (ids[i]) complete(ids[i]);
   endtask

   initial begin
      HRESETn = 0; HSEL = 0; HADDR = '0; HWDATA = '0; HWRITE = 0; HSIZE = 3'd2;
      HBURST = '0; HPROT = 4'h3; HTRANS = '0; HREADY = 1; src = '0;
      m_reset();
      repeat (2) @(posedge HCLK); #1;
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_hrdata", HRDATA, 32'd0);
      chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      chk("rst_hresp", {31'b0, HRESP}, 32'd0);
      HRESETn = 1; idle(1);
      foreach (m_prio[n]) begin bus_read(32'h20 + 32'(4 * n), rd); chk("rst_prio", rd, 32'd0); end
      bus_read(A_PEND, rd);  chk("rst_pend", rd, 32'd0);
      bus_read(A_EN, rd);    chk("rst_en", rd, 32'd0);
      bus_read(A_EDGE, rd);  chk("rst_edge", rd, 32'd0);
      bus_read(A_THR, rd);   chk("rst_thr", rd, 32'd0);
      bus_read(A_CLAIM, rd); chk("rst_claim", rd, 32'd0);
      bus_read(32'h40, rd);  chk("rst_unmapped", rd, 32'd0);

      // single level source: latency, claim, re-assert on complete
      set_prio(2, 5); set_en(8'h04); set_thr(0);
      set_src(8'h04);
      @(posedge HCLK); #1; chk("irq_lat1", {31'b0, irq}, 32'd0);
      @(posedge HCLK); #1; chk("irq_lat2", {31'b0, irq}, 32'd1);
      claim_chk("claim_src2", id);
      @(posedge HCLK); #1; chk("irq_drop", {31'b0, irq}, 32'd0);
      bus_read(A_PEND, rd); chk("pend_blocked", rd, 32'(m_pend));
      complete(3);
      chk_irq("irq_reassert");
      claim_chk("claim_src2_again", id);
      set_src('0); complete(3);
      chk_irq("irq_idle");

      // priority ordering and ties
      set_prio(2, 0); set_prio(1, 3); set_prio(4, 3); set_prio(6, 7); set_en(8'hFF);
      set_src(8'h52);
      chk_irq("prio_irq");
      for (int i = 0; i < 4; i++) claim_chk("prio_claim", id);

      // threshold
      set_thr(7); complete(7); complete(2); complete(5);
      chk_irq("thr7_irq");
      claim_chk("thr7_claim", id);
      set_thr(6);
      chk_irq("thr6_irq");
      claim_chk("thr6_claim", id);
      chk_irq("thr6_irq_after");
      complete(7); set_thr(0);
      drain("thr_drain");

      // HREADY low suppresses the claim; bad completes are ignored
      set_prio(3, 4); set_src(8'h08); idle(2);
      bus_read(A_PEND, rd); chk("hrdy_pend_before", rd, 32'(m_pend));
      HREADY = 0; HSEL = 1; HADDR = A_CLAIM; HWRITE = 0; HTRANS = 2'b10;
      @(posedge HCLK); #1;
      HREADY = 1; HSEL = 0; HTRANS = 2'b00;
      idle(1);
      bus_read(A_PEND, rd); chk("hrdy_pend_after", rd, 32'(m_pend));
      claim_chk("hrdy_claim", id);
      complete(9); complete(2);
      bus_read(A_PEND, rd); chk("badcmp_pend", rd, 32'(m_pend));
      claim_chk("badcmp_claim", id);
      complete(4);
      claim_chk("cmp4_claim", id);
      set_src('0); complete(4);

      // byte lanes
      bus_write(32'h05, 32'h0000FF5A, 3'd0);
      bus_read(A_EN, rd); chk("be_lane1", rd, 32'(m_en));
      bus_write(32'h04, 32'hFFFFFFA5, 3'd0); m_en = 8'hA5;
      bus_read(A_EN, rd); chk("be_lane0", rd, 32'(m_en));
      bus_write(32'h06, 32'h003C0000, 3'd1);
      bus_read(A_EN, rd); chk("be_hword_hi", rd, 32'(m_en));
      set_en(8'hFF);

`ifdef AHB3LITE_INTC_EDGE_EN
      set_en(8'h01); set_prio(0, 2);
      bus_write(A_EDGE, 32'h1); m_edge = 8'h01;
      bus_read(A_EDGE, rd); chk("edge_reg", rd, 32'h1);
      pulse(0);
      chk_irq("edge_irq");
      claim_chk("edge_claim1", id);
      pulse(0); pulse(0);
      bus_read(A_PEND, rd); chk("edge_pend_inservice", rd, 32'(m_pend));
      claim_chk("edge_claim_busy", id);
      complete(1);
      claim_chk("edge_claim2", id);
      complete(1);
      claim_chk("edge_claim_empty", id);
      bus_write(A_EDGE, 32'h0); m_edge = '0;
      set_en(8'hFF);
`else
      bus_write(A_EDGE, 32'hFF);
      bus_read(A_EDGE, rd); chk("edge_absent", rd, 32'd0);
`endif

      // randomized rounds
      for (int r = 0; r < 6; r++) begin
         int k;
         for (int n = 0; n < NS; n++) set_prio(n, int'($urandom_range(0, 7)));
         set_en(NS'($urandom_range(0, 255)));
         set_thr(int'($urandom_range(0, 3)));
         set_src(NS'($urandom_range(0, 255)));
         chk_irq("rnd_irq");
         bus_read(A_PEND, rd); chk("rnd_pend", rd, 32'(m_pend));
         k = int'($urandom_range(0, NS - 1));
         bus_read(32'h20 + 32'(4 * k), rd); chk("rnd_prio", rd, 32'(m_prio[k]));
         drain("rnd_claim");
         chk_irq("rnd_irq_end");
      end

      // reset in the middle of a transfer
      set_thr(0); set_prio(5, 6); set_src(8'h20);
      chk_irq("prereset_irq");
      bus_read(A_PEND, rd); chk("prereset_pend", rd, 32'(m_pend));
      HSEL = 1; HADDR = A_CLAIM; HWRITE = 0; HTRANS = 2'b10;
      #2 HRESETn = 0;
      #1 chk("async_irq", {31'b0, irq}, 32'd0);
      chk("async_hrdata", HRDATA, 32'd0);
      HSEL = 0; HTRANS = 2'b00; src = '0; m_reset();
      @(posedge HCLK); #1; HRESETn = 1; idle(1);
      bus_read(A_PEND, rd); chk("postrst_pend", rd, 32'd0);
      bus_read(32'h34, rd); chk("postrst_prio5", rd, 32'd0);
      chk_irq("postrst_irq");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb3lite_intc.md
# ahb3lite_intc

AHB3-Lite interrupt controller that collects interrupt lines, including `tint` from the timer, and presents one prioritised request `irq` to the CPU. Each source has a gateway, a pending bit, an enable bit and a priority. Software takes the highest-priority source through a claim register and returns it through a complete write to the same register. It is an AHB3-Lite slave on the same bus as the timer and uses the same zero-wait-state access rules.

## Interface
- `HADDR_SIZE`, 32, AHB address width
- `HDATA_SIZE`, 32, AHB data width; only 32 is supported
- `SOURCES`, 8, number of interrupt sources, legal range 1..31; source n has ID n+1
- `PRIO_BITS`, 3, width of each priority field
- `HCLK` input 1: the single clock
- `HRESETn` input 1: asynchronous, active-low reset
- `HSEL`, `HADDR`, `HWDATA`, `HWRITE`, `HSIZE`, `HBURST`, `HPROT`, `HTRANS`, `HREADY`: inputs, standard AHB3-Lite slave signals
- `HRDATA` output `HDATA_SIZE`: read data; `HREADYOUT` output 1: tied 1; `HRESP` output 1: tied OKAY
- `src` input `SOURCES`: interrupt lines, synchronous to `HCLK`, no synchroniser
- `irq` output 1: registered interrupt request to the CPU

## Operation
- Register map, all registers 32-bit:
  - 0x00 PENDING: read-only; writes ignored.
  - 0x04 ENABLE: read/write.
  - 0x08 EDGE: read/write, only when the edge feature is built in.
  - 0x0C THRESHOLD: read/write, `PRIO_BITS` wide.
  - 0x10 CLAIM/COMPLETE.
  - 0x20+4n PRIORITY[n].
- Other addresses read 0; writes to them are ignored. Unused bits read 0.
- Byte enables are decoded from HSIZE/HADDR[1:0]; partial writes update only the enabled bytes.
- Writes: address phase is registered; the register updates at the end of the data phase.
- Reads: HRDATA is registered from the address phase.
- Gateway:
  - Level source: pending[n] is set while `src[n]`=1 and inservice[n]=0.
  - Edge source: pending[n] is set on a 0→1 transition of `src[n]`, and is set even while in service.
- Pending is cleared only by a claim.
- Eligible: pending & enable & ~inservice, with priority > THRESHOLD. Priority 0 is never eligible.
- Arbiter picks the eligible source with the highest priority; on a tie, the lowest ID wins.
- The arbiter result best_id/best_prio is registered. best_id=0 when nothing is eligible.
- CLAIM read, qualified by HSEL & HREADY & !HWRITE & HTRANS NONSEQ/SEQ:
  - Returns best_id.
  - If best_id≠0: clears pending[best_id-1] and sets inservice[best_id-1].
- COMPLETE write of ID k: clears inservice[k-1]. k=0, k>SOURCES, or k not in service: no effect.
- `irq` = registered (best_prio > THRESHOLD and best_id≠0).

## Timing
- Reset values: HRDATA=0, irq=0, HREADYOUT=1, HRESP=0. All registers, pending, inservice and edge history are 0.
- `src` rising at edge k → pending=1 after edge k → best_id and irq valid after edge k+1.
- The arbiter input is the next-state pending/inservice. A claim therefore removes its source from best_id at the same edge, so back-to-back claims never return the same ID twice.
- Gateway set and claim clear of the same source in the same cycle: the set wins for edge sources; level sources are blocked by the inservice bit set by the claim.
- A COMPLETE write and a new edge in the same cycle are both applied.
- ENABLE, PRIORITY or THRESHOLD writes take effect on irq one cycle after the register update.
- HREADY low: no claim side effect and no register write.
- Reset asserted mid-transfer: all state clears immediately and irq drops asynchronously.

## Configuration
- `AHB3LITE_INTC_EDGE_EN` defined: EDGE register at 0x08 and per-source edge detection (bit=1 selects edge mode).
- Not defined: every source is level-sensitive, 0x08 reads 0, and no edge history flops are built.

## Structure
- HTRANS/HSIZE/HRESP encodings come from the shared `ahb3lite_pkg`.
- Register offsets and the byte-enable generation function go in a new package `ahb3lite_intc_pkg`.
- One sub-module, `ahb3lite_intc_arbiter`: combinational max-priority/lowest-ID tree over SOURCES entries. The top level registers its output.

## Test plan
- Reset, read every register → all 0; irq=0.
- PRIORITY[2]=5, ENABLE=0x4, THRESHOLD=0, pulse src[2] level high → irq=1 two edges later; CLAIM read returns 3; irq=0 next cycle; COMPLETE 3 with src[2] still high → irq re-asserts.
- Sources 1 and 4 at priority 3, source 6 at priority 7, all asserted → claims return 7, then 2, then 5, then 0.
- THRESHOLD=7 with all priorities ≤7 → irq stays 0 and CLAIM returns 0. THRESHOLD=6 → irq=1 only for the priority-7 source.
- With `AHB3LITE_INTC_EDGE_EN`: EDGE bit0=1, two pulses on src[0] while it is in service → pending stays 1; after COMPLETE 1, claim returns 1 once more.
- COMPLETE write of 9 with SOURCES=8, or of an ID not in service → no state change; CLAIM read with HREADY=0 → pending is unchanged.
